// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller: source count, code width
// and controller state encoding.
package int_pkg;

   localparam int unsigned NUM_IRQ = 4;
   localparam int unsigned CODE_W  = 2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BREAK,
      ST_SERVICE,
      ST_RET
   } state_t;

endpackage

// File: rtl/int_ctrl_prio_enc4.sv
// Fixed-priority encoder for four request lines; the lowest set index wins.
module prio_enc4 (
   input  logic [3:0] req,
   output logic [1:0] idx,
   output logic       valid
);

   always_comb begin
      idx   = 2'd0;
      valid = |req;
      casez (req)
         4'b???1: idx = 2'd0;
         4'b??10: idx = 2'd1;
         4'b?100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
   end

endmodule

// File: rtl/int_ctrl.sv
// Four-source nested interrupt controller: edge-captured pending bits,
// fixed priority, one-cycle break pulse, per-source in-service tracking.
module int_ctrl
   import int_pkg::*;
#(
   parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
   parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
   input  logic                in_CLK,
   input  logic                in_RST,
   input  logic [NUM_IRQ-1:0]  in_IRQ,
   input  logic                in_IE,
   input  logic [NUM_IRQ-1:0]  in_INM,
   input  logic                in_HOLD,
   input  logic                in_eret,
   output logic                out_BK,
   output logic                out_NIE,
   output logic [CODE_W-1:0]   out_code,
   output logic [31:0]         out_VEC,
   output logic [NUM_IRQ-1:0]  out_PEND,
   output logic [NUM_IRQ-1:0]  out_ISR,
   output logic                out_BUSY
);

   state_t               state, state_n;
   logic [NUM_IRQ-1:0]   pend, isr, irq_prev;
   logic [NUM_IRQ-1:0]   irq_edge, win_req, win_oh, top_oh;
   logic [CODE_W-1:0]    code, win_idx, top_idx;
   logic                 win_valid, top_valid, cand, take, do_ret;

   assign irq_edge = in_IRQ & ~irq_prev;
   assign win_req  = pend & ~in_INM;

   prio_enc4 u_win (.req(win_req), .idx(win_idx), .valid(win_valid));
   prio_enc4 u_top (.req(isr),     .idx(top_idx), .valid(top_valid));

   assign win_oh = 4'b0001 << win_idx;
   assign top_oh = 4'b0001 << top_idx;
   assign cand   = win_valid & in_IE & ~in_HOLD;

   // take/do_ret mark entry into BREAK/RET; the ISR/PEND/code updates happen on
   // that entry edge so the winner is frozen for the whole BREAK cycle.
   always_comb begin
      state_n = state;
      take    = 1'b0;
      do_ret  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cand) begin
               state_n = ST_BREAK;
               take    = 1'b1;
            end
         end
         ST_BREAK: state_n = ST_SERVICE;
         ST_SERVICE: begin
            if (in_eret) begin
               state_n = ST_RET;
               do_ret  = 1'b1;
            end else if (cand && (!top_valid || (win_idx < top_idx))) begin
               state_n = ST_BREAK;
               take    = 1'b1;
            end
         end
         ST_RET: state_n = (isr != '0) ? ST_SERVICE : ST_IDLE;
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge in_CLK) begin
      if (in_RST) begin
         state    <= ST_IDLE;
         pend     <= '0;
         isr      <= '0;
         irq_prev <= '0;
         code     <= '0;
      end else begin
         state    <= state_n;
         irq_prev <= in_IRQ;
         pend     <= (pend & ~(take ? win_oh : 4'b0000)) | irq_edge;
         if (take) begin
            isr  <= isr | win_oh;
            code <= win_idx;
         end else if (do_ret) begin
            isr  <= isr & ~top_oh;
         end
      end
   end

   assign out_BK   = (state == ST_BREAK);
   assign out_NIE  = (state != ST_BREAK);
   assign out_BUSY = (state != ST_IDLE);
   assign out_code = code;
   assign out_VEC  = VEC_BASE + (32'(code) * VEC_STRIDE);
   assign out_PEND = pend;
   assign out_ISR  = isr;

endmodule

// File: doc/int_ctrl.md
INT_CTRL -- requirements
Module: int_ctrl

Interface
REQ-001 Parameter VEC_BASE, default 32'h0000_0100; handler base address.
REQ-002 Parameter VEC_STRIDE, default 32'h0000_0010; address spacing between handlers.
REQ-003 One clock, in_CLK; reset is in_RST, synchronous and active-high.
REQ-004 in_CLK  input  1  system clock; all state updates on rising edge.
REQ-005 in_RST  input  1  synchronous active-high reset.
REQ-006 in_IRQ  input  4  interrupt request lines; rising edge = new request.
REQ-007 in_IE  input  1  global enable from CP0 IE bit.
REQ-008 in_INM  input  4  mask from CP0 INM; bit=1 masks that source.
REQ-009 in_HOLD  input  1  pipeline not at a safe break point (stall/flush); defers break.
REQ-010 in_eret  input  1  eret retiring this cycle.
REQ-011 out_BK  output  1  break pulse to CP0/pipeline (EPC capture, IE clear).
REQ-012 out_NIE  output  1  new IE value for CP0.
REQ-013 out_code  output  2  index of the source being taken.
REQ-014 out_VEC  output  32  handler address.
REQ-015 out_PEND  output  4  pending register.
REQ-016 out_ISR  output  4  in-service register.
REQ-017 out_BUSY  output  1  high when state is not IDLE.

Function
REQ-018 Rising edge on in_IRQ[i] (vs. registered previous sample) SHALL set PEND[i] on the next clock edge.
REQ-019 Priority: source 0 highest, 3 lowest; winner = lowest index of PEND & ~in_INM.
REQ-020 Candidate valid only when a winner exists, in_IE=1 and in_HOLD=0.
REQ-021 States: IDLE, BREAK, SERVICE, RET.
REQ-022 IDLE -> BREAK on valid candidate; otherwise stay.
REQ-023 BREAK lasts exactly one cycle: out_BK=1, out_NIE=0; set ISR[winner], clear PEND[winner], register out_code=winner; then -> SERVICE.
REQ-024 Winner SHALL be frozen on entry to BREAK; mask/IE changes during BREAK do not alter it.
REQ-025 SERVICE: in_eret -> RET; else valid candidate with index strictly lower than the highest-priority set ISR bit -> BREAK (nesting); else stay.
REQ-026 RET lasts one cycle: clear the highest-priority set ISR bit, out_NIE=1; -> SERVICE if ISR still nonzero, else IDLE.
REQ-027 out_NIE=1 in every state except BREAK.
REQ-028 out_VEC = VEC_BASE + out_code*VEC_STRIDE, 32-bit modulo arithmetic, combinational from registered out_code.
REQ-029 Edge on a bit in the same cycle it is cleared in BREAK: set wins, PEND stays 1.
REQ-030 Masked pending bits SHALL be retained, not dropped; taken once unmasked.
REQ-031 in_eret in IDLE or BREAK SHALL be ignored.
REQ-032 Equal- or lower-priority requests during SERVICE stay pending until ISR empties or a higher level retires.
REQ-033 Maximum nesting depth is 4 (one ISR bit per source); the same source is never nested on itself.
REQ-034 Latency: edge at cycle N -> PEND at N+1 -> out_BK at N+2 when idle, enabled, unmasked, in_HOLD=0.

Reset
REQ-035 in_RST=1 at a clock edge SHALL clear PEND, ISR, previous-IRQ sample, out_code; state -> IDLE; out_BK=0, out_NIE=1, out_BUSY=0, out_VEC=VEC_BASE.
REQ-036 Reset SHALL override every other event, including mid-BREAK or mid-RET.
REQ-037 An in_IRQ line held high through reset SHALL register as an edge on the first clock after reset release.

Structure
REQ-038 Shared package int_pkg SHALL hold the state encoding, NUM_IRQ=4 and the code width constant.
REQ-039 One sub-module prio_enc4: 4-bit request in, 2-bit index plus valid out, lowest index wins.

Verification
REQ-040 Single request: INM=0, IE=1, IRQ[2] rises at cycle 0 -> out_BK=1 at cycle 2, out_code=2, out_VEC=32'h0000_0120, ISR=4'b0100.
REQ-041 Simultaneous: IRQ[3] and IRQ[1] rise together -> source 1 taken first; source 3 taken only after eret empties ISR; PEND[3] stays 1 throughout.
REQ-042 Nesting: in service of 2, IRQ[0] rises with IE=1 -> second out_BK, ISR=4'b0101; first eret clears bit 0, second clears bit 2, then IDLE.
REQ-043 Mask/hold: INM=4'b0010, IRQ[1] rises -> no break, PEND=4'b0010; INM->0 while in_HOLD=1 -> no break; in_HOLD->0 -> out_BK next cycle.
REQ-044 Reset mid-operation: in_RST during SERVICE with PEND=4'b1000 -> all registers zero, IDLE, out_NIE=1; IRQ[3] held high -> taken after release.
